// File: rtl/sum_avg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sum_avg_pkg
//  Description : Shared definitions for the sum_averager block. Holds the
//                default widths and the accumulator FSM state encoding.
//                No ports.
//  Revision    : 1.0  initial release
// ============================================================================
package sum_avg_pkg;

    // Default configuration: 19-bit sum samples averaged over 2^4 = 16 samples
    localparam int DEF_IN_W  = 19;
    localparam int DEF_LOG2N = 4;

    // Accumulator FSM state encoding (explicit 1-bit width)
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } avg_state_e;

endpackage : sum_avg_pkg
`default_nettype wire

// File: rtl/sum_averager_avg_out_reg.sv
`default_nettype none
// ============================================================================
//  Module      : avg_out_reg
//  Description : Valid/ready holding register for finished averages. A new
//                average always overwrites the held one; if the held value
//                was still unconsumed it raises a sticky overrun flag.
//  Ports       : clk_i      - clock, rising edge
//                rst_ni     - asynchronous active-low reset
//                clr_i      - synchronous overrun clear (data/valid kept)
//                load_i     - a new average is presented on data_i
//                data_i     - new average value
//                ready_i    - consumer accepts data_o when valid_o is high
//                valid_o    - data_o holds an unconsumed average
//                data_o     - held average
//                overrun_o  - sticky: an unconsumed average was overwritten
//  Revision    : 1.0  initial release
// ============================================================================
module avg_out_reg #(
    parameter int W = 19
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         overrun_o
);

    logic         valid_q,   valid_d;
    logic [W-1:0] data_q,    data_d;
    logic         overrun_q, overrun_d;

    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        overrun_d = overrun_q;

        if (load_i) begin
            // A load always wins: the register stays valid with the new value.
            // Overrun only when the old value was neither consumed nor being
            // consumed this cycle.
            data_d  = data_i;
            valid_d = 1'b1;
            if (valid_q && !ready_i) begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        // clr never coincides with a load (the sample is discarded upstream),
        // so it only needs to drop the sticky flag.
        if (clr_i) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
        end
    end

    assign valid_o   = valid_q;
    assign data_o    = data_q;
    assign overrun_o = overrun_q;

endmodule : avg_out_reg
`default_nettype wire

// File: rtl/sum_averager.sv
`default_nettype none
// ============================================================================
//  Module      : sum_averager
//  Description : Averages windows of N = 2^LOG2N unsigned sum samples and
//                presents each window average through a valid/ready holding
//                register with overwrite-and-flag behaviour.
//                Build option: define SUM_AVG_ROUND_EN to round half up
//                instead of truncating the average.
//  Ports       : clk       - clock, rising edge
//                rst_n     - asynchronous active-low reset
//                enable    - start / continue averaging
//                clr       - synchronous window restart and overrun clear
//                in_valid  - in_data carries a sample this cycle
//                in_data   - IN_W-bit unsigned sum sample
//                avg_valid - avg_data holds an unconsumed average
//                avg_ready - consumer accepts avg_data
//                avg_data  - IN_W-bit window average
//                overrun   - sticky: an unconsumed average was overwritten
//  Parameters  : IN_W  - sample width
//                LOG2N - log2 of window length, legal range 1..8
//  Revision    : 1.0  initial release
// ============================================================================
module sum_averager
    import sum_avg_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int LOG2N = DEF_LOG2N
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic            clr,
    input  logic            in_valid,
    input  logic [IN_W-1:0] in_data,
    output logic            avg_valid,
    input  logic            avg_ready,
    output logic [IN_W-1:0] avg_data,
    output logic            overrun
);

    // N*(2^IN_W-1) always fits in IN_W+LOG2N bits, so the sum cannot wrap.
    localparam int ACC_W = IN_W + LOG2N;

    avg_state_e        state_q, state_d;
    logic [ACC_W-1:0]  acc_q,   acc_d;
    logic [LOG2N-1:0]  cnt_q,   cnt_d;

    logic [ACC_W-1:0]  sum_w;
    logic [ACC_W-1:0]  final_w;
    logic [IN_W-1:0]   avg_new_w;
    logic              load_w;
    logic              last_w;

    assign sum_w  = acc_q + ACC_W'(in_data);
    assign last_w = (cnt_q == {LOG2N{1'b1}});

`ifdef SUM_AVG_ROUND_EN
    // Half an LSB of the result; adding it cannot overflow because
    // N*(2^IN_W-1) + N/2 < N*2^IN_W.
    localparam logic [ACC_W-1:0] ROUND_C = ACC_W'(1) << (LOG2N - 1);
    assign final_w = sum_w + ROUND_C;
`else
    assign final_w = sum_w;
`endif

    assign avg_new_w = IN_W'(final_w >> LOG2N);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        load_w  = 1'b0;

        case (state_q)
            IDLE: begin
                // Samples are ignored here; accumulation starts next cycle.
                if (enable) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (!enable && (cnt_q == '0)) begin
                    // Leave only on a window boundary so no partial sum is lost
                    // mid-window.
                    state_d = IDLE;
                end else if (in_valid && !clr) begin
                    if (last_w) begin
                        load_w = 1'b1;
                        acc_d  = '0;
                        cnt_d  = '0;
                    end else begin
                        acc_d  = sum_w;
                        cnt_d  = cnt_q + LOG2N'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    avg_out_reg #(
        .W (IN_W)
    ) u_out_reg (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .clr_i     (clr),
        .load_i    (load_w),
        .data_i    (avg_new_w),
        .ready_i   (avg_ready),
        .valid_o   (avg_valid),
        .data_o    (avg_data),
        .overrun_o (overrun)
    );

endmodule : sum_averager
`default_nettype wire

// File: tb/tb_sum_averager.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sum_averager
//  Description : Self-checking bench for sum_averager (IN_W=19, LOG2N=4).
//                Table of full windows plus directed multi-cycle sequences
//                (overrun, clr, mid-window reset, load-while-consumed, idle).
//                Honours SUM_AVG_ROUND_EN for the expected averages.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sum_averager;

    localparam int IN_W  = 19;
    localparam int LOG2N = 4;
    localparam int N     = 1 << LOG2N;

    logic            clk;
    logic            rst_n;
    logic            enable;
    logic            clr;
    logic            in_valid;
    logic [IN_W-1:0] in_data;
    logic            avg_valid;
    logic            avg_ready;
    logic [IN_W-1:0] avg_data;
    logic            overrun;

    int n_vec;
    int n_fail;

    sum_averager #(
        .IN_W  (IN_W),
        .LOG2N (LOG2N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .avg_valid (avg_valid),
        .avg_ready (avg_ready),
        .avg_data  (avg_data),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic [IN_W-1:0] base;
        logic [IN_W-1:0] step;
        logic [IN_W-1:0] exp_avg;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One clock: inputs already set, outputs sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [IN_W-1:0] base, input logic [IN_W-1:0] step, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            in_valid = 1'b1;
            in_data  = IN_W'(base + IN_W'(i) * step);
            tick();
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic consume();
        avg_ready = 1'b1;
        tick();
        avg_ready = 1'b0;
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;

        vecs[0] = '{"const1000", 19'd1000,   19'd0, 19'd1000};
`ifdef SUM_AVG_ROUND_EN
        vecs[1] = '{"ramp0_15",  19'd0,      19'd1, 19'd8};
        vecs[4] = '{"ramp100s3", 19'd100,    19'd3, 19'd123};
`else
        vecs[1] = '{"ramp0_15",  19'd0,      19'd1, 19'd7};
        vecs[4] = '{"ramp100s3", 19'd100,    19'd3, 19'd122};
`endif
        vecs[2] = '{"fullscale", 19'd524287, 19'd0, 19'd524287};
        vecs[3] = '{"const2000", 19'd2000,   19'd0, 19'd2000};
        vecs[5] = '{"const7",    19'd7,      19'd0, 19'd7};

        rst_n     = 1'b0;
        enable    = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        avg_ready = 1'b0;
        tick();
        tick();
        chk("reset_valid",   32'(avg_valid), 32'd0);
        chk("reset_data",    32'(avg_data),  32'd0);
        chk("reset_overrun", 32'(overrun),   32'd0);
        rst_n = 1'b1;

        // Sample while idle must be ignored
        in_valid = 1'b1;
        in_data  = 19'd50000;
        tick();
        in_valid = 1'b0;
        enable   = 1'b1;
        tick();                       // IDLE -> ACCUM

        // ---------------- table of full windows ----------------
        for (int v = 0; v < 6; v++) begin
            feed(vecs[v].base, vecs[v].step, N - 1);
            chk({vecs[v].name, "_pre_valid"}, 32'(avg_valid), 32'd0);
            in_valid = 1'b1;
            in_data  = IN_W'(vecs[v].base + IN_W'(N - 1) * vecs[v].step);
            tick();
            in_valid = 1'b0;
            chk({vecs[v].name, "_valid"},   32'(avg_valid), 32'd1);
            chk({vecs[v].name, "_data"},    32'(avg_data),  32'(vecs[v].exp_avg));
            chk({vecs[v].name, "_overrun"}, 32'(overrun),   32'd0);
            consume();
            chk({vecs[v].name, "_consumed"}, 32'(avg_valid), 32'd0);
        end

        // ---------------- overrun across two windows, then clr ----------------
        feed(19'd1000, 19'd0, N);
        feed(19'd2000, 19'd0, N);
        chk("ovr_valid",   32'(avg_valid), 32'd1);
        chk("ovr_data",    32'(avg_data),  32'd2000);
        chk("ovr_flag",    32'(overrun),   32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_overrun", 32'(overrun),   32'd0);
        chk("clr_valid",   32'(avg_valid), 32'd1);
        chk("clr_data",    32'(avg_data),  32'd2000);
        consume();

        // ---------------- load while the held value is being consumed ------------
        feed(19'd1000, 19'd0, N);
        chk("simul_first_valid", 32'(avg_valid), 32'd1);
        feed(19'd3000, 19'd0, N - 1);
        avg_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 19'd3000;
        tick();
        in_valid  = 1'b0;
        avg_ready = 1'b0;
        chk("simul_valid",   32'(avg_valid), 32'd1);
        chk("simul_data",    32'(avg_data),  32'd3000);
        chk("simul_overrun", 32'(overrun),   32'd0);
        consume();

        // ---------------- clr mid-window discards partial sum ----------------
        feed(19'd5000, 19'd0, 8);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 19'd9999;          // coincident sample must be dropped
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        feed(19'd100, 19'd0, N - 1);
        chk("clrpart_pre_valid", 32'(avg_valid), 32'd0);
        feed(19'd100, 19'd0, 1);
        chk("clrpart_valid", 32'(avg_valid), 32'd1);
        chk("clrpart_data",  32'(avg_data),  32'd100);
        // leave this average unconsumed so the reset below has something to clear

        // ---------------- asynchronous reset mid-window ----------------
        feed(19'd5000, 19'd0, 8);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid",   32'(avg_valid), 32'd0);
        chk("rst_mid_data",    32'(avg_data),  32'd0);
        chk("rst_mid_overrun", 32'(overrun),   32'd0);
        tick();
        rst_n = 1'b1;
        tick();                       // IDLE -> ACCUM (enable still high)
        feed(19'd100, 19'd0, N);
        chk("rst_after_valid", 32'(avg_valid), 32'd1);
        chk("rst_after_data",  32'(avg_data),  32'd100);
        consume();

        // ---------------- disable at boundary, idle samples ignored ----------
        enable = 1'b0;
        tick();                       // ACCUM -> IDLE at count 0
        feed(19'd4000, 19'd0, N);
        chk("idle_ignored", 32'(avg_valid), 32'd0);
        enable = 1'b1;
        tick();
        feed(19'd200, 19'd0, N);
        chk("reenable_valid", 32'(avg_valid), 32'd1);
        chk("reenable_data",  32'(avg_data),  32'd200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_sum_averager
`default_nettype wire
